// File: rtl/icache_direct_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;
  localparam logic TRUE   = 1'b1;
  localparam logic FALSE  = 1'b0;
  localparam int   WORD_W = 32;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;
endpackage

// File: rtl/icache_direct_tag_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
// Only the valid bits are reset, so a reset invalidates every line at once.
module icache_direct_tag_array
  import icache_direct_pkg::*;
#(
  parameter  int INDEX_BITS = 8,
  localparam int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags  [LINES];
  logic [WORD_W-1:0]   words [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid           <= '0;
    else if (wr_en) valid[wr_index] <= TRUE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only I-cache: one-cycle hits, single-word miss fill
// from the memory controller, misses cancelled by roll.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter  int INDEX_BITS = 8,
  localparam int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll,
  input  logic        IF_flag,
  input  logic [31:0] IF_addr,
  output logic        IF_valid,
  output logic [31:0] IF_inst,
  output logic        MC_flag,
  output logic [31:0] MC_addr,
  input  logic        MC_commit,
  input  logic [31:0] MC_data
);
  ic_state_e state, state_nxt;
  logic [29:0] miss_addr, miss_addr_nxt;   // latched word address of the miss
  logic        valid_nxt, flag_nxt;
  logic [31:0] inst_nxt, maddr_nxt;
  logic        fill;

  logic [INDEX_BITS-1:0] req_index, miss_index;
  logic [TAG_BITS-1:0]   req_tag, miss_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [WORD_W-1:0]     rd_data;
  logic                  hit;
  logic                  addr_unused;

  assign req_index   = IF_addr[INDEX_BITS+1:2];
  assign req_tag     = IF_addr[31:INDEX_BITS+2];
  assign miss_index  = miss_addr[INDEX_BITS-1:0];
  assign miss_tag    = miss_addr[29:INDEX_BITS];
  assign hit         = rd_valid && (rd_tag == req_tag);
  assign addr_unused = ^IF_addr[1:0];

  icache_direct_tag_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (MC_data)
  );

  always_comb begin
    state_nxt     = state;
    miss_addr_nxt = miss_addr;
    valid_nxt     = FALSE;
    inst_nxt      = IF_inst;
    flag_nxt      = MC_flag;
    maddr_nxt     = MC_addr;
    fill          = FALSE;
    if (roll) begin
      // A word arriving with the flush is still correct for the latched line.
      fill      = (state == IC_MISS) && MC_commit;
      state_nxt = IC_IDLE;
      flag_nxt  = FALSE;
      maddr_nxt = '0;
    end else if (rdy) begin
      unique case (state)
        IC_IDLE: begin
          if (IF_flag) begin
            if (hit) begin
              valid_nxt = TRUE;
              inst_nxt  = rd_data;
            end else begin
              state_nxt     = IC_MISS;
              flag_nxt      = TRUE;
              maddr_nxt     = {IF_addr[31:2], 2'b00};
              miss_addr_nxt = IF_addr[31:2];
            end
          end
        end
        IC_MISS: begin
          // Flag stays high untouched until the commit; never glitch it.
          if (MC_commit) begin
            fill      = TRUE;
            valid_nxt = TRUE;
            inst_nxt  = MC_data;
            flag_nxt  = FALSE;
            maddr_nxt = '0;
            state_nxt = IC_IDLE;
          end
        end
        default: state_nxt = IC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IC_IDLE;
      miss_addr <= '0;
      IF_valid  <= FALSE;
      IF_inst   <= '0;
      MC_flag   <= FALSE;
      MC_addr   <= '0;
    end else begin
      state     <= state_nxt;
      miss_addr <= miss_addr_nxt;
      IF_valid  <= valid_nxt;
      IF_inst   <= inst_nxt;
      MC_flag   <= flag_nxt;
      MC_addr   <= maddr_nxt;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboarded bench for icache_direct: directed scenarios plus random fetches
// against a line-map model and a TB-side memory controller.
module tb_icache_direct;
  logic        clk = 0, rst = 0, rdy = 1, roll = 0;
  logic        IF_flag = 0, MC_commit = 0;
  logic [31:0] IF_addr = 0, MC_data = 0;
  logic        IF_valid, MC_flag;
  logic [31:0] IF_inst, MC_addr;

  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];
  bit   [255:0] mvalid;
  logic [29:0]  mline [256];   // word address currently held by each line

  icache_direct dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
    .IF_flag(IF_flag), .IF_addr(IF_addr), .IF_valid(IF_valid), .IF_inst(IF_inst),
    .MC_flag(MC_flag), .MC_addr(MC_addr), .MC_commit(MC_commit), .MC_data(MC_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_1004) return 32'h00A0_0093;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[9:2]] && (mline[a[9:2]] == a[31:2]);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Monitor: every IF_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && IF_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid actual=%h expected=none t=%0t", IF_inst, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (IF_inst !== e) begin
          failures++;
          $display("FAIL inst actual=%h expected=%h t=%0t", IF_inst, e, $time);
        end
      end
      checks++;
      if (MC_flag) begin
        failures++;
        $display("FAIL valid_with_flag actual=1 expected=0 t=%0t", $time);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Start a request at a negedge; returns after the edge that accepts it.
  task automatic issue(input logic [31:0] a, output bit hit);
    @(negedge clk);
    hit = model_hit(a);
    IF_flag = 1; IF_addr = a;
    if (hit) exp_q.push_back(mem_word(a));
    step();
    IF_flag = 0; IF_addr = $urandom;
    if (hit) begin
      chk("hit_valid", {31'd0, IF_valid}, 1);
      chk("hit_noflag", {31'd0, MC_flag}, 0);
    end else begin
      chk("miss_flag", {31'd0, MC_flag}, 1);
      chk("miss_addr", MC_addr, {a[31:2], 2'b00});
      chk("miss_novalid", {31'd0, IF_valid}, 0);
    end
  endtask

  // Memory controller: lat wait cycles (random rdy stalls), then commit.
  task automatic serve(input logic [31:0] a, input int lat);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 3) != 0);
      step();
      chk("wait_flag", {31'd0, MC_flag}, 1);
      chk("wait_addr", MC_addr, {a[31:2], 2'b00});
      chk("wait_novalid", {31'd0, IF_valid}, 0);
    end
    @(negedge clk);
    rdy = 1; MC_commit = 1; MC_data = mem_word(a);
    exp_q.push_back(mem_word(a));
    step();
    MC_commit = 0; MC_data = $urandom;
    chk("fill_valid", {31'd0, IF_valid}, 1);
    chk("fill_flag_low", {31'd0, MC_flag}, 0);
    chk("fill_addr_zero", MC_addr, 0);
    mvalid[a[9:2]] = 1; mline[a[9:2]] = a[31:2];
  endtask

  task automatic fetch(input logic [31:0] a);
    bit hit;
    issue(a, hit);
    if (!hit) serve(a, $urandom_range(0, 3));
  endtask

  initial begin
    bit hit;
    mvalid = '0;
    #3;
    chk("rst_valid", {31'd0, IF_valid}, 0);
    chk("rst_inst", IF_inst, 0);
    chk("rst_flag", {31'd0, MC_flag}, 0);
    chk("rst_addr", MC_addr, 0);
    #10 rst = 1;

    // Cold miss, hit, second line, back-to-back hits.
    fetch(32'h0000_1004);
    fetch(32'h0000_1004);
    fetch(32'h0000_1008);
    @(negedge clk);
    IF_flag = 1; IF_addr = 32'h0000_1004; exp_q.push_back(mem_word(32'h1004));
    step(); chk("b2b_first", {31'd0, IF_valid}, 1);
    @(negedge clk);
    IF_addr = 32'h0000_1008; exp_q.push_back(mem_word(32'h1008));
    step(); chk("b2b_second", {31'd0, IF_valid}, 1);
    IF_flag = 0;

    // Conflict eviction on the same index.
    fetch(32'h0000_1404);
    issue(32'h0000_1004, hit);
    chk("conflict_remiss", {31'd0, hit}, 0);
    if (!hit) serve(32'h0000_1004, 1);

    // Roll two cycles into a miss, with a concurrent request ignored.
    issue(32'h0000_2000, hit);
    step(); step();
    @(negedge clk);
    roll = 1; IF_flag = 1; IF_addr = 32'h0000_1004;
    step();
    roll = 0; IF_flag = 0;
    chk("roll_flag", {31'd0, MC_flag}, 0);
    chk("roll_addr", MC_addr, 0);
    chk("roll_novalid", {31'd0, IF_valid}, 0);
    step();
    chk("roll_no_service", {31'd0, IF_valid}, 0);
    issue(32'h0000_2000, hit);
    chk("roll_remiss", {31'd0, hit}, 0);
    if (!hit) serve(32'h0000_2000, 2);

    // Roll coinciding with commit still fills the line.
    issue(32'h0000_3000, hit);
    @(negedge clk);
    roll = 1; MC_commit = 1; MC_data = mem_word(32'h3000);
    step();
    roll = 0; MC_commit = 0;
    chk("rollc_novalid", {31'd0, IF_valid}, 0);
    chk("rollc_flag", {31'd0, MC_flag}, 0);
    mvalid[12'h000] = 1; mline[12'h000] = 30'h0000_3000 >> 2;
    issue(32'h0000_3000, hit);
    chk("rollc_filled", {31'd0, hit}, 1);

    // rdy stall during a miss.
    issue(32'h0000_4010, hit);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rdy = 0; MC_commit = k[0];
      step();
      chk("stall_flag", {31'd0, MC_flag}, 1);
      chk("stall_addr", MC_addr, 32'h0000_4010);
      chk("stall_novalid", {31'd0, IF_valid}, 0);
    end
    MC_commit = 0;
    serve(32'h0000_4010, 0);

    // Async reset mid-miss.
    issue(32'h0000_5020, hit);
    @(negedge clk);
    #2 rst = 0;
    #1 chk("arst_flag", {31'd0, MC_flag}, 0);
    chk("arst_addr", MC_addr, 0);
    #1 rst = 1;
    mvalid = '0;
    issue(32'h0000_1004, hit);
    chk("arst_remiss", {31'd0, hit}, 0);
    if (!hit) serve(32'h0000_1004, 1);

    // Random fetches over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      fetch(a);
    end

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
